// File: rtl/hazard_pkg.sv
// Shared types for the hazard-detection stage: the shadow-slot record that
// mirrors one in-flight instruction, and the empty-slot constant.
package hazard_pkg;

  localparam int HAZ_REG_W = 5;

  // One in-flight instruction as seen by hazard detection.
  typedef struct packed {
    logic                 v;     // slot holds a real instruction
    logic [HAZ_REG_W-1:0] rd;    // destination register
    logic                 we;    // writes rd
    logic                 ld;    // load: result not ready until MEM
    logic                 mem;   // uses the memory port (load or store)
    logic                 br;    // branch awaiting resolution
    logic                 pred;  // predicted direction for the branch
  } slot_t;

  localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-slot shadow of the EX/MEM/WB pipeline. A new entry is inserted into
// EX when the caller allows it; otherwise EX receives a bubble. MEM and WB
// always advance. Reset only clears the valid bits; payload is don't-care.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ins_en,
  input  slot_t ins_slot,
  output slot_t ex_slot,
  output slot_t mem_slot,
  output slot_t wb_slot
);

  slot_t slot_p0;  // EX
  slot_t slot_p1;  // MEM
  slot_t slot_p2;  // WB

  // Shift the shadow pipeline every cycle; reset kills every slot's valid.
  always_ff @(posedge clk) begin
    // ID -> EX
    slot_p0 <= ins_en ? ins_slot : BUBBLE;
    // EX -> MEM
    slot_p1 <= slot_p0;
    // MEM -> WB
    slot_p2 <= slot_p1;
    if (!rst_n) begin
      slot_p0.v <= 1'b0;
      slot_p1.v <= 1'b0;
      slot_p2.v <= 1'b0;
    end
  end

  assign ex_slot  = slot_p0;
  assign mem_slot = slot_p1;
  assign wb_slot  = slot_p2;

endmodule

// File: rtl/hazard_detect.sv
// Hazard qualifiers for the in-order 5-stage core: RAW detection against the
// shadow EX/MEM/WB writers, forwardability, memory-port conflict, branch
// tracking and a saturating freeze-cycle counter. REG_W must equal the
// package register width because the shadow slots store rd at that width.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W      = HAZ_REG_W,
  parameter int FWD_EN     = 1,
  parameter int SHARED_MEM = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             id_is_branch,
  input  logic             id_pred_taken,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  input  logic             freeze,
  input  logic             flush,
  output logic             data,
  output logic             fwrd,
  output logic             str,
  output logic             ctrl,
  output logic             branch,
  output logic             crct,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t ins_slot;
  logic  ins_en;
  slot_t ex_s;
  slot_t mem_s;
  slot_t wb_s;
  logic  ex_hit;
  logic  mem_hit;
  logic  wb_hit;
  logic  unused_slot_bits;

  // A writer in a slot feeds source idx unless it targets x0.
  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] idx,
                                      input logic used, input logic valid);
    return valid && used && s.v && s.we && (s.rd != '0) && (s.rd == HAZ_REG_W'(idx));
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Capture the ID instruction as a shadow slot; freeze or flush sends a bubble.
  always_comb begin
    ins_slot      = BUBBLE;
    ins_slot.v    = 1'b1;
    ins_slot.rd   = HAZ_REG_W'(id_rd);
    ins_slot.we   = id_rd_we;
    ins_slot.ld   = id_is_load;
    ins_slot.mem  = id_is_load | id_is_store;
    ins_slot.br   = id_is_branch;
    ins_slot.pred = id_pred_taken;
    ins_en        = id_valid && !freeze && !flush;
  end

  hazard_slot_pipe u_slots (
    .clk      (clk),
    .rst_n    (rst_n),
    .ins_en   (ins_en),
    .ins_slot (ins_slot),
    .ex_slot  (ex_s),
    .mem_slot (mem_s),
    .wb_slot  (wb_s)
  );

  // Decode RAW matches, forwardability, port conflict and branch status.
  always_comb begin
    ex_hit  = slot_match(ex_s,  id_rs1, id_rs1_used, id_valid) ||
              slot_match(ex_s,  id_rs2, id_rs2_used, id_valid);
    mem_hit = slot_match(mem_s, id_rs1, id_rs1_used, id_valid) ||
              slot_match(mem_s, id_rs2, id_rs2_used, id_valid);
    wb_hit  = slot_match(wb_s,  id_rs1, id_rs1_used, id_valid) ||
              slot_match(wb_s,  id_rs2, id_rs2_used, id_valid);
    data    = ex_hit || mem_hit || wb_hit;
    // A load still in EX has no result yet, which poisons the whole dependence.
    fwrd    = (FWD_EN != 0) && data && !(ex_hit && ex_s.ld);
    str     = (SHARED_MEM != 0) && id_valid && mem_s.v && mem_s.mem;
    ctrl    = (id_valid && id_is_branch) || (ex_s.v && ex_s.br);
    branch  = ex_br_valid && ex_s.v && ex_s.br;
    crct    = branch && (ex_br_taken == ex_s.pred);
  end

  // Count freeze cycles, saturating; cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (freeze) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign unused_slot_bits = ^{ex_s.mem, mem_s.ld, mem_s.br, mem_s.pred,
                              wb_s.ld, wb_s.mem, wb_s.br, wb_s.pred};

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: a default instance plus a variant with
// no forwarding network, a private memory port and a 4-bit stall counter.
module tb_hazard_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rd_we;
  logic       id_is_load, id_is_store, id_is_branch, id_pred_taken;
  logic       ex_br_valid, ex_br_taken, freeze, flush;

  logic        data0, fwrd0, str0, ctrl0, branch0, crct0;
  logic [15:0] cnt0;
  logic        data1, fwrd1, str1, ctrl1, branch1, crct1;
  logic [3:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_detect dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_is_branch(id_is_branch), .id_pred_taken(id_pred_taken),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken), .freeze(freeze), .flush(flush),
    .data(data0), .fwrd(fwrd0), .str(str0), .ctrl(ctrl0), .branch(branch0), .crct(crct0),
    .stall_cnt(cnt0)
  );

  hazard_detect #(.FWD_EN(0), .SHARED_MEM(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_is_branch(id_is_branch), .id_pred_taken(id_pred_taken),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken), .freeze(freeze), .flush(flush),
    .data(data1), .fwrd(fwrd1), .str(str1), .ctrl(ctrl1), .branch(branch1), .crct(crct1),
    .stall_cnt(cnt1)
  );

  // e0 = {data, fwrd, str, ctrl, branch, crct} of dut0; e1 = {fwrd, str} of dut1
  typedef struct packed {
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we, ld, st, br, pred, exv, ext, frz, fl;
    logic [5:0] e0;
    logic [1:0] e1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int vld, input int rs1, input int u1, input int rs2,
                              input int u2, input int rd, input int we, input int ld,
                              input int st, input int br, input int pred, input int exv,
                              input int ext, input int frz, input int fl,
                              input logic [5:0] e0, input logic [1:0] e1);
    vec_t v;
    v.vld = 1'(vld);  v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2); v.u2 = 1'(u2);
    v.rd = 5'(rd);    v.we = 1'(we);   v.ld = 1'(ld); v.st = 1'(st);   v.br = 1'(br);
    v.pred = 1'(pred); v.exv = 1'(exv); v.ext = 1'(ext); v.frz = 1'(frz); v.fl = 1'(fl);
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
    id_rd = v.rd; id_rd_we = v.we; id_is_load = v.ld; id_is_store = v.st;
    id_is_branch = v.br; id_pred_taken = v.pred; ex_br_valid = v.exv; ex_br_taken = v.ext;
    freeze = v.frz; flush = v.fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] outs0();
    return {data0, fwrd0, str0, ctrl0, branch0, crct0};
  endfunction

  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 6'b0, 2'b0);

    // Load-use with one freeze cycle, then the load reaches MEM
    vq.push_back(mk(1,0,0,0,0,5,1, 1,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,5,1,0,0,6,1, 0,0,0,0, 0,0,1,0, 6'b100000, 2'b00));
    vq.push_back(mk(1,5,1,0,0,6,1, 0,0,0,0, 0,0,0,0, 6'b111000, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    // ALU forward from EX on rs2
    vq.push_back(mk(1,0,0,0,0,3,1, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,0,3,1,0,0, 0,0,0,0, 0,0,0,0, 6'b110000, 2'b00));
    // x0 writer never matches
    vq.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    // unused rs2 does not match; then rd=7 visible from MEM and WB, gone after
    vq.push_back(mk(1,0,0,0,0,7,1, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,1,1,7,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,0,7,1,0,0, 0,0,0,0, 0,0,0,0, 6'b110000, 2'b00));
    vq.push_back(mk(1,0,0,7,1,0,0, 0,0,0,0, 0,0,0,0, 6'b110000, 2'b00));
    vq.push_back(mk(1,0,0,7,1,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    // Store reaches MEM while ID is valid
    vq.push_back(mk(1,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b001000, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    // Branch pred=1 resolved not-taken, then taken, then a stray resolve
    vq.push_back(mk(1,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0, 6'b000100, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,0,0,0, 6'b000110, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0, 6'b000100, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,1,0,0, 6'b000111, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,1,0,0, 6'b000000, 2'b00));
    // Branch resolves in the flush cycle; flushed ID writer leaves no hazard
    vq.push_back(mk(1,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0, 6'b000100, 2'b00));
    vq.push_back(mk(1,0,0,0,0,9,1, 0,0,0,0, 1,0,0,1, 6'b000111, 2'b00));
    vq.push_back(mk(1,9,1,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    // freeze and flush together: bubble
    vq.push_back(mk(1,0,0,0,0,4,1, 0,0,0,0, 0,0,1,1, 6'b000000, 2'b00));
    vq.push_back(mk(1,4,1,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    // Same rd in EX (load) and MEM (ALU): non-forwardable overall
    vq.push_back(mk(1,0,0,0,0,8,1, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,0,0,0,0,8,1, 1,0,0,0, 0,0,0,0, 6'b000000, 2'b00));
    vq.push_back(mk(1,8,1,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b100000, 2'b00));
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 2'b00));

    // Reset state
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outs", 32'(outs0()), 32'd0);
    chk("reset_cnt", 32'(cnt0), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs0()), 32'(vq[i].e0));
      chk($sformatf("vec%0d_variant", i), 32'({fwrd1, str1}), 32'(vq[i].e1));
    end
    @(negedge clk);
    drive(idle);
    #1;
    chk("table_stall_cnt", 32'(cnt0), 32'd2);
    chk("table_stall_cnt_var", 32'(cnt1), 32'd2);

    // Fill all slots (rd10, rd11, branch), then reset mid-run
    @(negedge clk); drive(mk(1,0,0,0,0,10,1, 0,0,0,0, 0,0,0,0, 6'b0, 2'b0));
    @(negedge clk); drive(mk(1,0,0,0,0,11,1, 0,0,0,0, 0,0,0,0, 6'b0, 2'b0));
    @(negedge clk); drive(mk(1,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0, 6'b0, 2'b0));
    @(negedge clk); drive(mk(1,10,1,11,1,0,0, 0,0,0,0, 0,0,0,0, 6'b0, 2'b0));
    #1;
    chk("filled_outs", 32'(outs0()), 32'(6'b110100));
    chk("filled_cnt", 32'(cnt0), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle);
    #1;
    chk("in_reset_outs", 32'(outs0()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1,10,1,11,1,0,0, 0,0,0,0, 1,1,0,0, 6'b0, 2'b0));
    #1;
    chk("post_reset_outs", 32'(outs0()), 32'd0);
    chk("post_reset_cnt", 32'(cnt0), 32'd0);
    chk("post_reset_cnt_var", 32'(cnt1), 32'd0);

    // Freeze for 2^4+3 cycles: 4-bit counter saturates, 16-bit one keeps counting
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,1,0, 6'b0, 2'b0));
    repeat (14) @(negedge clk);
    #1;
    chk("sat_cnt_mid", 32'(cnt1), 32'd14);
    repeat (5) @(negedge clk);
    drive(idle);
    #1;
    chk("sat_cnt_var", 32'(cnt1), 32'd15);
    chk("sat_cnt_wide", 32'(cnt0), 32'd19);
    @(negedge clk); #1;
    chk("sat_cnt_hold", 32'(cnt1), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_detect.md
# hazard_detect

Upstream hazard-detection stage for the in-order 5-stage core. It compares the instruction in decode (ID) against a shadow pipeline of in-flight writers in EX, MEM and WB, and tracks the unresolved branch in EX. From this it produces the data, str, ctrl, branch, fwrd and crct qualifiers consumed by the hazard-resolver FSM. It also takes the resolver's pc_freeze and do_flush back, so the shadow pipeline stays aligned with the real one.

## Interface
- REG_W, 5: register-index width.
- FWD_EN, 1: forwarding network present. When 0, fwrd is always 0.
- SHARED_MEM, 1: single memory port shared by fetch and MEM. When 0, str is always 0.
- CNT_W, 16: width of the stall-cycle counter.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_W  source indices.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_W  destination index.
- id_rd_we  in  1  instruction writes rd.
- id_is_load, id_is_store, id_is_branch  in  1  instruction class.
- id_pred_taken  in  1  predictor's direction for an ID branch.
- ex_br_valid  in  1  branch unit resolves the EX branch this cycle.
- ex_br_taken  in  1  resolved direction.
- freeze  in  1  resolver pc_freeze; ID is held.
- flush  in  1  resolver do_flush; the ID instruction is killed.
- data  out  1  RAW hazard on the ID instruction.
- fwrd  out  1  every matching RAW hazard is forwardable.
- str  out  1  structural memory-port conflict.
- ctrl  out  1  branch in ID or EX, including its resolve cycle.
- branch  out  1  branch resolution pulse.
- crct  out  1  prediction was correct. Valid only with branch, otherwise 0.
- stall_cnt  out  CNT_W  saturating count of freeze cycles.

## Operation
- Shadow slot fields: v, rd, we, ld, mem, br, pred. There are three slots, EX, MEM and WB.
- Advance every cycle:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields when id_valid && !freeze && !flush.
  - Otherwise EX<=bubble (v=0).
- Match rule: a slot matches source s if all of these hold:
  - slot v and we are set;
  - slot rd != 0;
  - slot rd == s;
  - s is used and id_valid is set.
- data is asserted when any slot matches rs1 or rs2.
- Forwardability:
  - An EX match with ld=1 (load-use) is not forwardable.
  - All other EX, MEM and WB matches are forwardable.
  - fwrd = FWD_EN && data && no non-forwardable match.
- str = SHARED_MEM && id_valid && MEM.v && MEM.mem.
- ctrl = (id_valid && id_is_branch) || (EX.v && EX.br).
- Branch resolution:
  - branch = ex_br_valid && EX.v && EX.br.
  - An ex_br_valid with no branch in EX is ignored: branch=0, crct=0.
  - crct = branch && (ex_br_taken == EX.pred).
- stall_cnt increments on each cycle with freeze=1 and holds at all-ones.
- All outputs except stall_cnt are combinational from ID inputs, registered slots and ex_br_*.

## Timing
- Reset (rst_n=0 at a clk edge): all slots v=0 and stall_cnt=0.
- During and after reset, data, fwrd, str, ctrl, branch and crct are all 0 until ID inputs drive them.
- Zero-cycle latency from ID inputs to outputs. Slot updates take effect at the next edge.
- Hazard lifetimes:
  - A load-use dependence shows data=1, fwrd=0 for exactly 1 cycle if freeze is applied. The load then moves to MEM and fwrd=1.
  - A writer stays visible for 3 cycles after entering EX.
- Simultaneous events:
  - freeze and flush together: flush wins, EX gets a bubble.
  - branch and flush in the same cycle: branch/crct are still reported, and the EX branch advances to MEM (no longer ctrl).
  - A match in multiple slots is treated as non-forwardable if any one match is non-forwardable.
- rst_n low mid-operation clears all slots at that edge. The counter also resets.

## Structure
- hazard_pkg holds:
  - the REG_W default;
  - the slot struct typedef (v, rd, we, ld, mem, br, pred);
  - the BUBBLE constant.
- Sub-module hazard_slot_pipe holds the three-slot shadow pipeline: insert, bubble and advance logic.
- The top level holds the match/forward decode, branch tracking and stall_cnt.

## Test plan
- Load-use: cycle 0 inserts a load with rd=5. Cycle 1 puts an ID instruction with rs1=5 used. Required: data=1, fwrd=0. Apply freeze for 1 cycle, then data=1, fwrd=1.
- ALU forward: EX holds rd=3, we, ld=0. ID reads rs2=3. Required: data=1, fwrd=1. With FWD_EN=0, fwrd=0.
- x0 and unused sources:
  - EX writes rd=0 and ID reads rs1=0: data=0.
  - rd=7 matches only rs2 with rs2_used=0: data=0.
- Structural hazard: a store sits in MEM while ID is valid. Required: str=1. With SHARED_MEM=0, str=0.
- Branch:
  - A branch with pred=1 enters EX. Next cycle ex_br_valid=1, taken=0. Required: ctrl=1, branch=1, crct=0 for one cycle.
  - Repeat with taken=1: crct=1.
  - An ex_br_valid with no branch in EX: branch=0.
- Reset mid-run: fill all slots, then hold rst_n=0 for one edge. Required: all outputs 0 and stall_cnt=0. Also drive freeze for 2^CNT_W+3 cycles and confirm stall_cnt saturates at all-ones.
